// File: rtl/bus_xfer_seq_pkg.sv
// Shared constants for the register-bus transfer sequencer: FSM encodings,
// bus source ids and destination write-enable bit positions.
package bus_xfer_seq_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_MEM_RD   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_WRITE    = 2'd3;

    // Bus source ids; 0 is data memory, the rest are zero-latency registers.
    localparam int SRC_MEM = 0;
    localparam int SRC_AC  = 1;
    localparam int SRC_MQ  = 2;
    localparam int SRC_PC  = 3;
    localparam int SRC_IR  = 4;
    localparam int SRC_MAR = 5;
    localparam int SRC_MBR = 6;
    localparam int SRC_SR  = 7;

    localparam int DST_AC  = 0;
    localparam int DST_MQ  = 1;
    localparam int DST_PC  = 2;
    localparam int DST_IR  = 3;
    localparam int DST_MAR = 4;
    localparam int DST_MBR = 5;
    localparam int DST_SR  = 6;
    localparam int DST_OUT = 7;

endpackage

// File: rtl/bus_xfer_seq_src_mux.sv
// Combinational NSRC:1 selector over the flattened source words.
// Out-of-range select yields zero.
module bus_src_mux #(
    parameter int N    = 12,
    parameter int NSRC = 8
) (
    input  logic [NSRC*N-1:0]        src_data,
    input  logic [$clog2(NSRC)-1:0]  sel,
    output logic [N-1:0]             word
);

    localparam int SW = $clog2(NSRC);

    always_comb begin
        word = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (sel == SW'(i)) begin
                word = src_data[i*N +: N];
            end
        end
    end

endmodule

// File: rtl/bus_xfer_seq.sv
// Register-bus transfer sequencer: one command at a time, registered bus word and write enables.
// Register source writes 1 cycle after accept, memory source MEM_LAT+2; `BUS_XFER_SEQ_ERR_EN adds sticky err.
module bus_xfer_seq
    import bus_xfer_seq_pkg::*;
#(
    parameter int N       = 12,
    parameter int NSRC    = 8,
    parameter int NDST    = 8,
    parameter int MEM_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [$clog2(NSRC)-1:0]  cmd_src,
    input  logic [NDST-1:0]          cmd_dst,
    input  logic [NSRC*N-1:0]        src_data,
    output logic                     mem_rd_en,
    output logic [N-1:0]             bus_out,
    output logic [NDST-1:0]          dst_write_en,
    output logic                     done
`ifdef BUS_XFER_SEQ_ERR_EN
    ,
    output logic                     err
`endif
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NDST-1:0] mask_q, mask_d;
    logic [N-1:0]    bus_q, bus_d;
    logic [NDST-1:0] wen_q, wen_d;
    logic            done_q, done_d;
    logic [N-1:0]    sel_word;
    logic            src_oob;
    logic            src_is_mem;
    logic            accept;

    bus_src_mux #(
        .N    (N),
        .NSRC (NSRC)
    ) u_src_mux (
        .src_data (src_data),
        .sel      (cmd_src),
        .word     (sel_word)
    );

    assign src_oob    = (32'(cmd_src) >= NSRC);
    assign src_is_mem = (32'(cmd_src) == SRC_MEM);
    assign accept     = cmd_valid && (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        bus_d   = bus_q;
        wen_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (src_oob) begin
                        // Unknown source: run as a no-write and leave the bus alone.
                        mask_d  = '0;
                        state_d = ST_WRITE;
                        done_d  = 1'b1;
                    end else if (src_is_mem) begin
                        mask_d  = cmd_dst;
                        state_d = ST_MEM_RD;
                    end else begin
                        bus_d   = sel_word;
                        mask_d  = cmd_dst;
                        wen_d   = cmd_dst;
                        done_d  = 1'b1;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_MEM_RD: begin
                cnt_d   = CW'(MEM_LAT - 1);
                state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                if (cnt_q == '0) begin
                    bus_d   = src_data[N-1:0];
                    wen_d   = mask_q;
                    done_d  = 1'b1;
                    state_d = ST_WRITE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mask_q  <= '0;
            bus_q   <= '0;
            wen_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            bus_q   <= bus_d;
            wen_q   <= wen_d;
            done_q  <= done_d;
        end
    end

`ifdef BUS_XFER_SEQ_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (accept && (src_oob || (cmd_dst == '0)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign cmd_ready    = (state_q == ST_IDLE);
    assign mem_rd_en    = (state_q == ST_MEM_RD);
    assign bus_out      = bus_q;
    assign dst_write_en = wen_q;
    assign done         = done_q;

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq; NSRC=6 so out-of-range source ids fit the 3-bit command field.
module tb_bus_xfer_seq;

    localparam int N       = 12;
    localparam int NSRC    = 6;
    localparam int NDST    = 8;
    localparam int MEM_LAT = 2;

    logic                     clk;
    logic                     rst;
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [$clog2(NSRC)-1:0]  cmd_src;
    logic [NDST-1:0]          cmd_dst;
    logic [NSRC*N-1:0]        src_data;
    logic                     mem_rd_en;
    logic [N-1:0]             bus_out;
    logic [NDST-1:0]          dst_write_en;
    logic                     done;
`ifdef BUS_XFER_SEQ_ERR_EN
    logic                     err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bus_xfer_seq #(
        .N       (N),
        .NSRC    (NSRC),
        .NDST    (NDST),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .src_data     (src_data),
        .mem_rd_en    (mem_rd_en),
        .bus_out      (bus_out),
        .dst_write_en (dst_write_en),
        .done         (done)
`ifdef BUS_XFER_SEQ_ERR_EN
        ,
        .err          (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int idx, input logic [N-1:0] w);
        src_data[idx*N +: N] = w;
    endtask

    task automatic issue(input logic [2:0] src, input logic [NDST-1:0] dst);
        cmd_src   = src;
        cmd_dst   = dst;
        cmd_valid = 1'b1;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_src   = '0;
        cmd_dst   = '0;
        src_data  = '0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_bus", bus_out, 0);
        check("rst_wen", dst_write_en, 0);
        check("rst_memrd", mem_rd_en, 0);
        check("rst_done", done, 0);
`ifdef BUS_XFER_SEQ_ERR_EN
        check("rst_err", err, 0);
`endif
        step();
        step();
        rst = 1'b0;

        // Register source 3 -> destination bit 1
        set_src(3, 12'h5A5);
        issue(3'd3, 8'b0000_0010);
        check("reg_ready_pre", cmd_ready, 1);
        step();
        cmd_valid = 1'b0;
        check("reg_wen", dst_write_en, 8'h02);
        check("reg_bus", bus_out, 12'h5A5);
        check("reg_done", done, 1);
        check("reg_ready_busy", cmd_ready, 0);
        step();
        check("reg_wen_off", dst_write_en, 0);
        check("reg_done_off", done, 0);
        check("reg_ready_back", cmd_ready, 1);
        check("reg_bus_hold", bus_out, 12'h5A5);

        // Memory source with cmd_valid held through the sequence
        set_src(0, 12'h0F3);
        issue(3'd0, 8'b0000_0100);
        step();
        check("mem_rd_t1", mem_rd_en, 1);
        check("mem_ready_t1", cmd_ready, 0);
        issue(3'd3, 8'b0000_1000);
        step();
        check("mem_rd_t2", mem_rd_en, 0);
        check("mem_wen_t2", dst_write_en, 0);
        check("mem_ready_t2", cmd_ready, 0);
        step();
        check("mem_rd_t3", mem_rd_en, 0);
        check("mem_wen_t3", dst_write_en, 0);
        check("mem_bus_t3", bus_out, 12'h5A5);
        step();
        check("mem_wen_t4", dst_write_en, 8'h04);
        check("mem_bus_t4", bus_out, 12'h0F3);
        check("mem_done_t4", done, 1);
        check("mem_ready_t4", cmd_ready, 0);
        step();
        check("mem_ready_t5", cmd_ready, 1);
        check("mem_wen_t5", dst_write_en, 0);
        step();
        cmd_valid = 1'b0;
        check("held_wen", dst_write_en, 8'h08);
        check("held_bus", bus_out, 12'h5A5);
        step();

        // Multi-hot destination from source 5
        set_src(5, 12'hFFF);
        issue(3'd5, 8'b1000_0001);
        step();
        cmd_valid = 1'b0;
        check("multi_wen", dst_write_en, 8'h81);
        check("multi_bus", bus_out, 12'hFFF);
        step();
        check("multi_wen_off", dst_write_en, 0);

        // Reset asserted in MEM_WAIT
        set_src(0, 12'h0AB);
        issue(3'd0, 8'hFF);
        step();
        cmd_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("arst_bus", bus_out, 0);
        check("arst_wen", dst_write_en, 0);
        check("arst_memrd", mem_rd_en, 0);
        check("arst_done", done, 0);
        check("arst_ready", cmd_ready, 1);
        step();
        rst = 1'b0;
        check("arst_ready_rel", cmd_ready, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            check("arst_no_wen", dst_write_en, 0);
            check("arst_no_done", done, 0);
        end

        // Register data is captured at the accept edge
        set_src(3, 12'h001);
        issue(3'd3, 8'b0000_0010);
        step();
        cmd_valid = 1'b0;
        set_src(3, 12'h002);
        check("snap_bus", bus_out, 12'h001);
        check("snap_wen", dst_write_en, 8'h02);
        step();
        check("snap_bus_hold", bus_out, 12'h001);

        // Out-of-range source (NSRC=6): no write, bus untouched, done pulses
        issue(3'd6, 8'h01);
        step();
        cmd_valid = 1'b0;
        check("oob_wen", dst_write_en, 0);
        check("oob_done", done, 1);
        check("oob_bus", bus_out, 12'h001);
`ifdef BUS_XFER_SEQ_ERR_EN
        check("oob_err", err, 1);
`endif
        step();
        check("oob_done_off", done, 0);

        // Empty destination mask: sequence runs, bus updates, no enables
        set_src(4, 12'h123);
        issue(3'd4, 8'h00);
        step();
        cmd_valid = 1'b0;
        check("nodst_wen", dst_write_en, 0);
        check("nodst_done", done, 1);
        check("nodst_bus", bus_out, 12'h123);
        step();

        // Good command afterwards; err must remain sticky
        set_src(2, 12'h456);
        issue(3'd2, 8'h10);
        step();
        cmd_valid = 1'b0;
        check("good_wen", dst_write_en, 8'h10);
        check("good_bus", bus_out, 12'h456);
`ifdef BUS_XFER_SEQ_ERR_EN
        check("err_sticky", err, 1);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
